// File: rtl/fetch.sv
// ---------------------------------------------------------------------------
// fetch -- instruction fetch stage for the in-order RISC-V core.
//
// Keeps the fetch PC, issues one word request per cycle on the instruction
// memory port and buffers returned words, tagged with their PCs, in a small
// FIFO that decode drains. Decode can hold the head, and a redirect from
// execute flushes the FIFO and restarts fetch at a new address.
//
// Optional feature macro: FETCH_MISALIGN_TRAP_EN
//   defined   : a redirect to a non word-aligned target halts fetch and raises
//               misalign_out until the next aligned redirect or reset.
//   undefined : redirect targets are forced word-aligned, misalign_out = 0.
//
// Parameters
//   RESET_PC       first fetch address after reset
//   DEPTH          FIFO entries (power of two, >= 2)
//
// Ports
//   req            clock (all state updates on its rising edge)
//   rst            synchronous active-high reset
//   stall_in       decode hold; 1 = do not pop the head
//   redirect_in    taken branch/jump; flush and restart
//   redirect_pc_in new fetch address
//   imem_req_out   request valid
//   imem_addr_out  request word address (the fetch PC)
//   imem_ack_in    memory accepts request, data returned in the same cycle
//   imem_rdata_in  returned instruction word
//   valid_out      FIFO head valid
//   instr_out      head instruction, NOP (32'h13) when not valid
//   pc_out         head PC, 0 when not valid
//   misalign_out   misaligned redirect flag
// ---------------------------------------------------------------------------
module fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        req,
    input  logic        rst,
    input  logic        stall_in,
    input  logic        redirect_in,
    input  logic [31:0] redirect_pc_in,
    output logic        imem_req_out,
    output logic [31:0] imem_addr_out,
    input  logic        imem_ack_in,
    input  logic [31:0] imem_rdata_in,
    output logic        valid_out,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        misalign_out
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic [31:0] fetch_pc;
    logic [31:0] pc_mem    [DEPTH];
    logic [31:0] instr_mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          halt;
    logic [31:0]   target_pc;
    logic          push;
    logic          pop;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic target_misaligned;
    assign target_pc         = redirect_pc_in;
    assign target_misaligned = (redirect_pc_in[1:0] != 2'b00);
    assign misalign_out      = halt;
`else
    logic unused_low_bits;
    assign unused_low_bits = &{1'b0, redirect_pc_in[1:0]};
    assign target_pc       = {redirect_pc_in[31:2], 2'b00};
    assign halt            = 1'b0;
    assign misalign_out    = 1'b0;
`endif

    // Request uses the registered count, so a pop in this cycle cannot make
    // room for a request in the same cycle.
    assign imem_req_out  = !rst && !redirect_in && (count != FULL) && !halt;
    assign imem_addr_out = fetch_pc;

    assign valid_out = (count != '0);
    assign instr_out = valid_out ? instr_mem[rd_ptr] : NOP;
    assign pc_out    = valid_out ? pc_mem[rd_ptr]    : 32'h0000_0000;

    assign push = imem_req_out && imem_ack_in;
    assign pop  = valid_out && !stall_in;

    // Priority: reset, then redirect (flush + retarget), then push/pop.
    always_ff @(posedge req) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
            halt     <= 1'b0;
`endif
        end else if (redirect_in) begin
            fetch_pc <= target_pc;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
            halt     <= target_misaligned;
`endif
        end else begin
            if (push) begin
                pc_mem[wr_ptr]    <= fetch_pc;
                instr_mem[wr_ptr] <= imem_rdata_in;
                wr_ptr            <= wr_ptr + 1'b1;
                fetch_pc          <= fetch_pc + 32'd4;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule
